// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with return-address stack.
//
// Selects the next PC each rising clk edge with priority
//   trap_req > mret_req > jump_enable > branEnable > PC+4.
// A jump/branch whose target is not word aligned is turned into a trap
// (PC <= trap_vector, epc <= PC) and flagged on misalign for one cycle.
// Jumps qualified by call/ret push/pop a circular return-address stack.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   stall                 hold PC, epc and RAS (a trap still proceeds)
//   jump_enable           unconditional redirect to jump_target_address
//   call / ret            qualify the jump as call (push) / return (pop)
//   branEnable            taken branch to branAddress
//   trap_req, trap_vector exception/interrupt and its handler address
//   mret_req              return from trap to epc
//   outputPCAddress       current PC
//   pc_plus4              current PC + 4
//   epc                   saved exception PC
//   ras_empty, ras_full   RAS occupancy flags
//   misalign              one-cycle pulse after a misaligned redirect
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            jump_enable,
  input  logic            call,
  input  logic            ret,
  input  logic [XLEN-1:0] jump_target_address,
  input  logic            branEnable,
  input  logic [XLEN-1:0] branAddress,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret_req,
  output logic [XLEN-1:0] outputPCAddress,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign
);

  localparam int unsigned     PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;

  logic             ras_has;
  logic [XLEN-1:0]  jump_target;
  logic [XLEN-1:0]  redirect_target;
  logic             bad_target;

  assign pc_plus4        = pc_q + XLEN'(4);
  assign ras_has         = (cnt_q != '0);
  // A return with an empty stack falls back to the explicit jump target.
  assign jump_target     = (ret && ras_has) ? ras_mem[top_q] : jump_target_address;
  assign redirect_target = jump_enable ? jump_target : branAddress;
  assign bad_target      = (jump_enable || branEnable) && (redirect_target[1:0] != 2'b00);

  always_comb begin
    pc_d       = pc_plus4;
    epc_d      = epc_q;
    top_d      = top_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    ras_we     = 1'b0;
    ras_waddr  = top_q;
    if (trap_req) begin
      pc_d  = trap_vector;
      epc_d = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (mret_req) begin
      pc_d = epc_q;
    end else if (bad_target) begin
      // Misaligned redirect: trap instead, leave the RAS alone.
      pc_d       = trap_vector;
      epc_d      = pc_q;
      misalign_d = 1'b1;
    end else if (jump_enable) begin
      pc_d = jump_target;
      if (call && ret && ras_has) begin
        // Pop followed by push collapses to overwriting the top entry.
        ras_we    = 1'b1;
        ras_waddr = top_q;
      end else if (call) begin
        // When full, advancing the pointer overwrites the oldest entry.
        ras_we    = 1'b1;
        ras_waddr = top_q + 1'b1;
        top_d     = top_q + 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (ret && ras_has) begin
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (branEnable) begin
      pc_d = branAddress;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      top_q      <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // Stack storage has no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_waddr] <= pc_plus4;
  end

  assign outputPCAddress = pc_q;
  assign epc             = epc_q;
  assign ras_empty       = (cnt_q == '0);
  assign ras_full        = (cnt_q == CNT_MAX);
  assign misalign        = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed-vector bench for pc_sequencer (XLEN=32,
// RESET_VECTOR=0, RAS_DEPTH=4). Inputs change 1 ns after each rising edge
// and outputs are sampled there too.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, jump_enable, call, ret, branEnable, trap_req, mret_req;
  logic [31:0] jump_target_address, branAddress, trap_vector;
  logic [31:0] outputPCAddress, pc_plus4, epc;
  logic        ras_empty, ras_full, misalign;

  int unsigned vec_count   = 0;
  int unsigned miscompares = 0;

  pc_sequencer #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .RAS_DEPTH   (4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .stall              (stall),
    .jump_enable        (jump_enable),
    .call               (call),
    .ret                (ret),
    .jump_target_address(jump_target_address),
    .branEnable         (branEnable),
    .branAddress        (branAddress),
    .trap_req           (trap_req),
    .trap_vector        (trap_vector),
    .mret_req           (mret_req),
    .outputPCAddress    (outputPCAddress),
    .pc_plus4           (pc_plus4),
    .epc                (epc),
    .ras_empty          (ras_empty),
    .ras_full           (ras_full),
    .misalign           (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; jump_enable = 0; call = 0; ret = 0; branEnable = 0;
    trap_req = 0; mret_req = 0;
    jump_target_address = '0; branAddress = '0; trap_vector = 32'h80;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge with a plain jump (optionally call/ret qualified), inputs cleared after.
  task automatic do_jump(input logic [31:0] tgt, input logic c, input logic r);
    idle_inputs();
    jump_enable = 1; call = c; ret = r; jump_target_address = tgt;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    #3;
    check("rst_pc", outputPCAddress, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_epc", epc, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_full", {31'b0, ras_full}, 32'h0);
    check("rst_mis", {31'b0, misalign}, 32'h0);
    #9 reset_n = 1;   // t=12, between edges

    // Sequential run from reset vector
    tick(); check("seq_4", outputPCAddress, 32'h4);
    tick(); check("seq_8", outputPCAddress, 32'h8);
    tick(); check("seq_c", outputPCAddress, 32'hC);
    check("seq_empty", {31'b0, ras_empty}, 32'h1);
    tick(); check("seq_10", outputPCAddress, 32'h10);

    // Call and return
    do_jump(32'h100, 1, 0);
    check("call_pc", outputPCAddress, 32'h100);
    check("call_empty", {31'b0, ras_empty}, 32'h0);
    tick(); check("call_seq", outputPCAddress, 32'h104);
    do_jump(32'h0, 0, 1);
    check("ret_pc", outputPCAddress, 32'h14);
    check("ret_empty", {31'b0, ras_empty}, 32'h1);

    // RAS overflow: five calls into a 4-deep stack
    do_jump(32'h0, 0, 0);
    check("ovf_start", outputPCAddress, 32'h0);
    for (int unsigned i = 1; i <= 5; i++) begin
      do_jump(32'h100 * i, 1, 0);
      check("ovf_call_pc", outputPCAddress, 32'h100 * i);
      if (i == 3) check("ovf_notfull", {31'b0, ras_full}, 32'h0);
      if (i >= 4) check("ovf_full", {31'b0, ras_full}, 32'h1);
    end
    for (int unsigned i = 4; i >= 1; i--) begin
      do_jump(32'h600, 0, 1);
      check("ovf_ret_pc", outputPCAddress, 32'h100 * i + 32'h4);
    end
    check("ovf_empty", {31'b0, ras_empty}, 32'h1);
    do_jump(32'h600, 0, 1);
    check("ovf_ret_emptyfb", outputPCAddress, 32'h600);

    // Trap beats stall/jump/call; mret returns to epc
    do_jump(32'h20, 0, 0);
    trap_req = 1; jump_enable = 1; stall = 1; call = 1;
    jump_target_address = 32'h300; trap_vector = 32'h80;
    tick(); idle_inputs();
    check("trap_pc", outputPCAddress, 32'h80);
    check("trap_epc", epc, 32'h20);
    check("trap_nocall", {31'b0, ras_empty}, 32'h1);
    mret_req = 1; jump_enable = 1; jump_target_address = 32'h300;
    tick(); idle_inputs();
    check("mret_pc", outputPCAddress, 32'h20);
    check("mret_epc", epc, 32'h20);

    // Stall holds PC and ignores jump/call
    stall = 1; jump_enable = 1; call = 1; jump_target_address = 32'h300;
    tick(); idle_inputs();
    check("stall_pc", outputPCAddress, 32'h20);
    check("stall_ras", {31'b0, ras_empty}, 32'h1);
    check("stall_mis", {31'b0, misalign}, 32'h0);

    // Misaligned branch -> trap path with one-cycle misalign pulse
    do_jump(32'h40, 0, 0);
    branEnable = 1; branAddress = 32'h42; trap_vector = 32'h80;
    tick(); idle_inputs();
    check("misb_pc", outputPCAddress, 32'h80);
    check("misb_epc", epc, 32'h40);
    check("misb_pulse", {31'b0, misalign}, 32'h1);
    tick();
    check("misb_pc_next", outputPCAddress, 32'h84);
    check("misb_pulse_end", {31'b0, misalign}, 32'h0);

    // Misaligned call: trap, RAS untouched
    do_jump(32'h201, 1, 0);
    check("misj_pc", outputPCAddress, 32'h80);
    check("misj_epc", epc, 32'h84);
    check("misj_mis", {31'b0, misalign}, 32'h1);
    check("misj_ras", {31'b0, ras_empty}, 32'h1);

    // Jump beats branch; aligned branch taken
    jump_enable = 1; jump_target_address = 32'h300; branEnable = 1; branAddress = 32'h400;
    tick(); idle_inputs();
    check("prio_jump", outputPCAddress, 32'h300);
    branEnable = 1; branAddress = 32'h500;
    tick(); idle_inputs();
    check("bran_pc", outputPCAddress, 32'h500);

    // call+ret together: target from RAS top, top replaced by PC+4
    do_jump(32'h600, 1, 0);
    check("cr_setup", outputPCAddress, 32'h600);
    do_jump(32'h700, 1, 1);
    check("cr_pc", outputPCAddress, 32'h504);
    check("cr_notempty", {31'b0, ras_empty}, 32'h0);
    do_jump(32'h0, 0, 1);
    check("cr_ret", outputPCAddress, 32'h604);
    check("cr_empty", {31'b0, ras_empty}, 32'h1);

    // Wrap-around
    do_jump(32'hFFFF_FFFC, 0, 0);
    check("wrap_pc4", pc_plus4, 32'h0);
    tick();
    check("wrap_pc", outputPCAddress, 32'h0);

    // Reset while stalled with a redirect pending
    do_jump(32'h1000, 1, 0);
    stall = 1; jump_enable = 1; jump_target_address = 32'h2000;
    tick();
    check("prerst_pc", outputPCAddress, 32'h1000);
    #2 reset_n = 0;
    #1;
    check("mrst_pc", outputPCAddress, 32'h0);
    check("mrst_epc", epc, 32'h0);
    check("mrst_empty", {31'b0, ras_empty}, 32'h1);
    @(negedge clk);
    reset_n = 1;
    idle_inputs();
    tick();
    check("postrst_pc", outputPCAddress, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
